// File: rtl/riscv_i32_mem_stage.sv
// riscv_i32_mem_stage: RV32I memory stage with aligned dmem access, lane steering, load extension and bus timeout
module riscv_i32_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_op,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rd_written,
  input  logic [1:0]  ex_memory_width,
  input  logic        ex_memory_read_unsigned,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_arith_result,
  input  logic [31:0] ex_store_data,
  output logic        dmem_req_valid,
  output logic [31:0] dmem_address,
  output logic        dmem_write,
  output logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_write_data,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_read_data,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_rd_written,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  output logic [1:0]  wb_exception_cause
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;
  logic [31:0] cnt;
  logic is_load, is_store, misaligned;
  logic [3:0] be;
  logic [31:0] wdata, load_data;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [4:0] acc_rd;
  logic acc_rd_written, acc_unsigned;
  logic [1:0] acc_width, acc_off;
  assign ex_ready = state == IDLE;
  // decode the incoming op, steer store lanes and extract load data for the captured access
  always_comb begin
    is_load = ex_op == 4'd6;
    is_store = ex_op == 4'd7;
    misaligned = ex_memory_width == 2'd3 || (ex_memory_width == 2'd1 && ex_arith_result[0]) ||
                 (ex_memory_width == 2'd2 && ex_arith_result[1:0] != 2'd0);
    be = ex_memory_width == 2'd0 ? 4'b0001 << ex_arith_result[1:0] :
         ex_memory_width == 2'd1 ? (ex_arith_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = ex_memory_width == 2'd0 ? {4{ex_store_data[7:0]}} :
            ex_memory_width == 2'd1 ? {2{ex_store_data[15:0]}} : ex_store_data;
    lb = dmem_read_data[{acc_off, 3'b000} +: 8];
    lh = acc_off[1] ? dmem_read_data[31:16] : dmem_read_data[15:0];
    load_data = acc_width == 2'd0 ? {{24{~acc_unsigned & lb[7]}}, lb} :
                acc_width == 2'd1 ? {{16{~acc_unsigned & lh[15]}}, lh} : dmem_read_data;
  end
  // accept ops, run the dmem access with timeout, and emit the one-cycle writeback record
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      dmem_req_valid <= 1'b0;
      dmem_address <= '0;
      dmem_write <= 1'b0;
      dmem_byte_enable <= '0;
      dmem_write_data <= '0;
      acc_rd <= '0;
      acc_rd_written <= 1'b0;
      acc_unsigned <= 1'b0;
      acc_width <= '0;
      acc_off <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_rd_written <= 1'b0;
      wb_data <= '0;
      wb_exception <= 1'b0;
      wb_exception_cause <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_rd_written <= 1'b0;
      wb_data <= '0;
      wb_exception <= 1'b0;
      wb_exception_cause <= '0;
      if (state == IDLE) begin
        if (ex_valid && (is_load || is_store) && misaligned) begin
          wb_valid <= 1'b1;
          wb_rd <= ex_rd;
          wb_exception <= 1'b1;
          wb_exception_cause <= is_load ? 2'd1 : 2'd2;
        end else if (ex_valid && (is_load || is_store)) begin
          state <= ACCESS;
          cnt <= '0;
          dmem_req_valid <= 1'b1;
          dmem_address <= {ex_arith_result[31:2], 2'b00};
          dmem_write <= is_store;
          dmem_byte_enable <= be;
          dmem_write_data <= wdata;
          acc_rd <= ex_rd;
          acc_rd_written <= ex_rd_written;
          acc_unsigned <= ex_memory_read_unsigned;
          acc_width <= ex_memory_width;
          acc_off <= ex_arith_result[1:0];
        end else if (ex_valid) begin
          wb_valid <= 1'b1;
          wb_rd <= ex_rd;
          wb_rd_written <= ex_rd_written && ex_rd != 5'd0;
          wb_data <= ex_result;
        end
      end else if (dmem_ack || (TIMEOUT_CYCLES != 0 && cnt == 32'(TIMEOUT_CYCLES - 1))) begin
        state <= IDLE;
        cnt <= '0;
        dmem_req_valid <= 1'b0;
        dmem_address <= '0;
        dmem_write <= 1'b0;
        dmem_byte_enable <= '0;
        dmem_write_data <= '0;
        wb_valid <= 1'b1;
        wb_rd <= acc_rd;
        wb_rd_written <= dmem_ack && !dmem_write && acc_rd_written && acc_rd != 5'd0;
        wb_data <= dmem_ack && !dmem_write ? load_data : 32'd0;
        wb_exception <= !dmem_ack;
        wb_exception_cause <= dmem_ack ? 2'd0 : 2'd3;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_riscv_i32_mem_stage.sv
// tb_riscv_i32_mem_stage: randomized and directed checks of the memory stage against an arithmetic reference model
module tb_riscv_i32_mem_stage;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ex_valid = 1'b0, ex_ready;
  logic [3:0] ex_op = '0;
  logic [4:0] ex_rd = '0;
  logic ex_rd_written = 1'b0;
  logic [1:0] ex_memory_width = '0;
  logic ex_memory_read_unsigned = 1'b0;
  logic [31:0] ex_result = '0, ex_arith_result = '0, ex_store_data = '0;
  logic dmem_req_valid, dmem_write;
  logic [31:0] dmem_address, dmem_write_data;
  logic [3:0] dmem_byte_enable;
  logic dmem_ack = 1'b0;
  logic [31:0] dmem_read_data = '0;
  logic wb_valid, wb_rd_written, wb_exception;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic [1:0] wb_exception_cause;
  int checks = 0, failures = 0;

  riscv_i32_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_rd(ex_rd), .ex_rd_written(ex_rd_written), .ex_memory_width(ex_memory_width),
    .ex_memory_read_unsigned(ex_memory_read_unsigned), .ex_result(ex_result),
    .ex_arith_result(ex_arith_result), .ex_store_data(ex_store_data),
    .dmem_req_valid(dmem_req_valid), .dmem_address(dmem_address), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable), .dmem_write_data(dmem_write_data), .dmem_ack(dmem_ack),
    .dmem_read_data(dmem_read_data), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_rd_written(wb_rd_written), .wb_data(wb_data), .wb_exception(wb_exception),
    .wb_exception_cause(wb_exception_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_wb(input logic v, input logic [4:0] rd, input logic rdw, input logic [31:0] d,
                          input logic exc, input logic [1:0] cause);
    check("wb_valid", wb_valid, v);
    check("wb_rd", wb_rd, rd);
    check("wb_rd_written", wb_rd_written, rdw);
    check("wb_data", wb_data, d);
    check("wb_exception", wb_exception, exc);
    check("wb_cause", wb_exception_cause, cause);
  endtask

  // called at a negedge with the stage idle; returns at a negedge with the stage idle
  task automatic run_op(input logic [3:0] op, input logic [4:0] rd, input logic rdw, input logic [1:0] w,
                        input logic uns, input logic [31:0] res, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rdata, input int delay);
    logic mem, misal, is_st, done;
    logic [31:0] exp_be, exp_wd, v;
    int off;
    mem = op == 4'd6 || op == 4'd7;
    is_st = op == 4'd7;
    off = int'(addr % 4);
    misal = mem && (w == 2'd3 || off % (1 << int'(w)) != 0);
    check("ready_idle", ex_ready, 1'b1);
    ex_valid = 1'b1; ex_op = op; ex_rd = rd; ex_rd_written = rdw; ex_memory_width = w;
    ex_memory_read_unsigned = uns; ex_result = res; ex_arith_result = addr; ex_store_data = sd;
    @(negedge clk);
    ex_valid = 1'b0; ex_op = 4'd0; ex_result = $urandom; ex_arith_result = $urandom; ex_store_data = $urandom;
    if (!mem || misal) begin
      check("no_req", dmem_req_valid, 1'b0);
      check_wb(1'b1, rd, !mem && rdw && rd != 0, mem ? 32'd0 : res, misal, misal ? (is_st ? 2'd2 : 2'd1) : 2'd0);
    end else begin
      exp_be = w == 2'd0 ? 32'd1 << off : w == 2'd1 ? 32'd3 << off : 32'd15;
      exp_wd = w == 2'd0 ? {24'd0, sd[7:0]} * 32'h0101_0101 : w == 2'd1 ? {16'd0, sd[15:0]} * 32'h0001_0001 : sd;
      done = 1'b0;
      for (int c = 1; !done; c++) begin
        check("req_valid", dmem_req_valid, 1'b1);
        check("req_addr", dmem_address, addr - 32'(off));
        check("req_write", dmem_write, is_st);
        check("req_be", dmem_byte_enable, exp_be);
        if (is_st) check("req_wdata", dmem_write_data, exp_wd);
        check("ready_access", ex_ready, 1'b0);
        check("wb_quiet", wb_valid, 1'b0);
        if (c == delay + 1 && c <= TO) begin
          dmem_ack = 1'b1; dmem_read_data = rdata;
          @(negedge clk);
          dmem_ack = 1'b0; dmem_read_data = $urandom;
          v = rdata >> (8 * off);
          if (w == 2'd0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v - 256;
          end else if (w == 2'd1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v - 65536;
          end
          check_wb(1'b1, rd, !is_st && rdw && rd != 0, is_st ? 32'd0 : v, 1'b0, 2'd0);
          done = 1'b1;
        end else if (c == TO) begin
          @(negedge clk);
          check("req_dropped", dmem_req_valid, 1'b0);
          check_wb(1'b1, rd, 1'b0, 32'd0, 1'b1, 2'd3);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    check("ready_after", ex_ready, 1'b1);
    @(negedge clk);
    check("wb_pulse_end", wb_valid, 1'b0);
  endtask

  initial begin
    logic [3:0] op;
    logic [1:0] w;
    logic [31:0] a;
    @(negedge clk);
    @(negedge clk);
    check_wb(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 2'd0);
    check("rst_req", dmem_req_valid, 1'b0);
    check("rst_addr", dmem_address, 32'd0);
    check("rst_be", dmem_byte_enable, 4'd0);
    check("rst_wdata", dmem_write_data, 32'd0);
    check("rst_ready", ex_ready, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(4'd6, 5'd5, 1'b1, 2'd0, 1'b0, 32'd0, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0);
    run_op(4'd6, 5'd6, 1'b1, 2'd1, 1'b1, 32'd0, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 3);
    run_op(4'd7, 5'd0, 1'b0, 2'd0, 1'b0, 32'd0, 32'h0000_0103, 32'h1234_56A5, 32'd0, 0);
    run_op(4'd6, 5'd7, 1'b1, 2'd2, 1'b0, 32'd0, 32'h0000_1002, 32'd0, 32'd0, 0);
    run_op(4'd7, 5'd0, 1'b0, 2'd2, 1'b0, 32'd0, 32'h0000_1001, 32'h55, 32'd0, 0);
    run_op(4'd6, 5'd8, 1'b1, 2'd3, 1'b0, 32'd0, 32'h0000_1000, 32'd0, 32'd0, 0);
    run_op(4'd6, 5'd9, 1'b1, 2'd2, 1'b0, 32'd0, 32'h0000_3000, 32'd0, 32'hCAFE_F00D, 10);
    run_op(4'd6, 5'd9, 1'b1, 2'd2, 1'b0, 32'd0, 32'h0000_3000, 32'd0, 32'hCAFE_F00D, 3);
    ex_valid = 1'b1; ex_op = 4'd0; ex_rd = 5'd3; ex_rd_written = 1'b1; ex_result = 32'd5;
    @(negedge clk);
    check_wb(1'b1, 5'd3, 1'b1, 32'd5, 1'b0, 2'd0);
    ex_rd = 5'd4; ex_result = 32'd6;
    @(negedge clk);
    check_wb(1'b1, 5'd4, 1'b1, 32'd6, 1'b0, 2'd0);
    ex_rd = 5'd0; ex_result = 32'd7;
    @(negedge clk);
    check_wb(1'b1, 5'd0, 1'b0, 32'd7, 1'b0, 2'd0);
    ex_valid = 1'b0;
    @(negedge clk);
    check("b2b_end", wb_valid, 1'b0);
    ex_valid = 1'b1; ex_op = 4'd6; ex_rd = 5'd10; ex_memory_width = 2'd2; ex_arith_result = 32'h0000_4000;
    @(negedge clk);
    ex_valid = 1'b0;
    check("rstmid_req", dmem_req_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1 check("rstmid_drop", dmem_req_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_nowb", wb_valid, 1'b0);
      check("stray_ack_noreq", dmem_req_valid, 1'b0);
    end
    dmem_ack = 1'b0;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: begin op = 4'($urandom_range(0, 13)); if (op >= 4'd6) op = op + 4'd2; end
        1: op = 4'd6;
        default: op = 4'd7;
      endcase
      w = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 9) < 7) a = w == 2'd0 ? a : w == 2'd1 ? a & ~32'd1 : a & ~32'd3;
      run_op(op, 5'($urandom), 1'($urandom), w, 1'($urandom), $urandom, a, $urandom, $urandom,
             int'($urandom_range(0, 5)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
